// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the sequential
// binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  function automatic logic [DIGIT_W-1:0] digit_adj3(
    input logic [DIGIT_W-1:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_stage.sv
// bcd_dabble_stage: one double-dabble step across all scratch digits,
// add-3 adjust then shift left by one with a new lsb.
module bcd_dabble_stage
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic [DIGIT_W*DIGITS-1:0] scratch,
  input  logic                      lsb,
  output logic [DIGIT_W*DIGITS-1:0] adj,
  output logic                      carry
);

  localparam int BCD_W = DIGIT_W * DIGITS;

  logic [BCD_W-1:0] fixed;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign fixed[DIGIT_W*i +: DIGIT_W] =
      digit_adj3(scratch[DIGIT_W*i +: DIGIT_W]);
  end

  // top bit of the adjusted vector is the one lost by the shift
  assign carry = fixed[BCD_W-1];
  assign adj   = {fixed[BCD_W-2:0], lsb};

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative shift-add-3 binary-to-BCD converter with
// start/done handshake, signed input, saturation and zero blanking.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
) (
  input  logic                      clk_100kHz,
  input  logic                      rst_,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]         en,
  output logic                      neg,
  output logic                      ovf
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_t           state;
  logic [BIN_W-1:0] bin_q;
  logic             sm_q;
  logic [BIN_W-1:0] mag;
  logic             neg_next;
  logic             sticky;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_nxt;
  logic [BCD_W-1:0] bcd_nxt;
  logic             carry;
  logic             sticky_nxt;
  logic             any_nz;
  logic [DIGITS-1:0] en_nxt;
  logic [CNT_W-1:0] cnt;

  bcd_dabble_stage #(
    .DIGITS(DIGITS)
  ) u_dabble (
    .scratch(scratch),
    .lsb    (mag[BIN_W-1]),
    .adj    (scratch_nxt),
    .carry  (carry)
  );

  assign sticky_nxt = sticky | carry;
  assign bcd_nxt    = sticky_nxt ? {DIGITS{4'h9}} : scratch_nxt;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // blank a digit only when it and every digit above it are zero
  always_comb begin
    en_nxt = '0;
    any_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz    = any_nz | (|bcd_nxt[DIGIT_W*i +: DIGIT_W]);
      en_nxt[i] = any_nz;
    end
    en_nxt[0] = 1'b1;
    if (sticky_nxt) en_nxt = '1;
  end

  always_ff @(posedge clk_100kHz) begin
    if (rst_) begin
      state    <= IDLE;
      bin_q    <= '0;
      sm_q     <= 1'b0;
      mag      <= '0;
      neg_next <= 1'b0;
      sticky   <= 1'b0;
      scratch  <= '0;
      cnt      <= '0;
      bcd      <= '0;
      en       <= DIGITS'(1);
      neg      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            bin_q <= bin;
            sm_q  <= signed_mode;
            state <= LOAD;
          end
        end
        LOAD: begin
          neg_next <= sm_q & bin_q[BIN_W-1];
          mag      <= (sm_q & bin_q[BIN_W-1])
                      ? BIN_W'(0) - bin_q : bin_q;
          scratch  <= '0;
          sticky   <= 1'b0;
          cnt      <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          mag     <= mag << 1;
          sticky  <= sticky_nxt;
          cnt     <= cnt + CNT_W'(1);
          // final step: results land so they are valid with done
          if (cnt == LAST) begin
            state <= DONE;
            bcd   <= bcd_nxt;
            en    <= en_nxt;
            ovf   <= sticky_nxt;
            neg   <= neg_next & (sticky_nxt | (|scratch_nxt));
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: random and directed conversions on a 32/8 and an
// 8/3 instance, checked every cycle against an arithmetic model.
module tb_bin_to_bcd_seq;

  logic clk_100kHz = 1'b0;
  always #5 clk_100kHz = ~clk_100kHz;

  logic        rst_;
  logic        start_a, sm_a;
  logic [31:0] bin_a;
  logic        busy_a, done_a, neg_a, ovf_a;
  logic [31:0] bcd_a;
  logic [7:0]  en_a;

  logic        start_b, sm_b;
  logic [7:0]  bin_b;
  logic        busy_b, done_b, neg_b, ovf_b;
  logic [11:0] bcd_b;
  logic [2:0]  en_b;

  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(8)) dut_a (
    .clk_100kHz(clk_100kHz), .rst_(rst_), .start(start_a),
    .signed_mode(sm_a), .bin(bin_a), .busy(busy_a), .done(done_a),
    .bcd(bcd_a), .en(en_a), .neg(neg_a), .ovf(ovf_a)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_b (
    .clk_100kHz(clk_100kHz), .rst_(rst_), .start(start_b),
    .signed_mode(sm_b), .bin(bin_b), .busy(busy_b), .done(done_b),
    .bcd(bcd_b), .en(en_b), .neg(neg_b), .ovf(ovf_b)
  );

  int errors = 0;
  int checks = 0;
  int wid[2] = '{32, 8};
  int dig[2] = '{8, 3};

  // ---------------- behavioural model ----------------
  function automatic void ref_conv(
    input int w, input int d, input logic [63:0] b, input bit sm,
    output logic [63:0] rbcd, output logic [63:0] ren,
    output bit rneg, output bit rovf
  );
    longint unsigned mag, lim, v, p10;
    bit isneg;
    isneg = sm && b[w-1];
    mag = b & ((64'd1 << w) - 64'd1);
    if (isneg) mag = (64'd1 << w) - mag;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    rovf = (mag >= lim);
    rneg = isneg && (mag != 0);
    rbcd = '0;
    ren = '0;
    v = mag;
    p10 = 1;
    for (int i = 0; i < d; i++) begin
      rbcd[4*i +: 4] = rovf ? 4'h9 : 4'(v % 10);
      v = v / 10;
      ren[i] = rovf || (i == 0) || (mag >= p10 * 10 && i > 0)
               || (i > 0 && mag >= p10 * 10);
      if (i > 0) ren[i] = rovf || (mag >= p10);
      p10 = p10 * 10;
    end
  endfunction

  longint      cyc = 0;
  longint      p;
  bit          armed = 0;
  longint      busy_from[2], idle_from[2], done_cyc[2];
  logic [63:0] exp_bcd[2], exp_en[2], res_bcd[2], res_en[2];
  bit          exp_neg[2], exp_ovf[2], res_neg[2], res_ovf[2];
  logic        m_st;
  logic [63:0] m_bin;
  logic        m_sm;

  always @(posedge clk_100kHz) begin
    p = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      m_st  = (k == 0) ? start_a : start_b;
      m_bin = (k == 0) ? 64'(bin_a) : 64'(bin_b);
      m_sm  = (k == 0) ? sm_a : sm_b;
      if (rst_) begin
        armed = 1;
        exp_bcd[k] = '0;
        exp_en[k] = 64'd1;
        exp_neg[k] = 0;
        exp_ovf[k] = 0;
        done_cyc[k] = -1;
        busy_from[k] = p;
        idle_from[k] = p;
      end else begin
        if (p == done_cyc[k]) begin
          exp_bcd[k] = res_bcd[k];
          exp_en[k] = res_en[k];
          exp_neg[k] = res_neg[k];
          exp_ovf[k] = res_ovf[k];
        end
        if (m_st && cyc >= idle_from[k]) begin
          ref_conv(wid[k], dig[k], m_bin, m_sm,
                   res_bcd[k], res_en[k], res_neg[k], res_ovf[k]);
          busy_from[k] = p;
          done_cyc[k] = cyc + wid[k] + 2;
          idle_from[k] = cyc + wid[k] + 3;
        end
      end
    end
    cyc = p;
  end

  // ---------------- access helpers ----------------
  function automatic void get(
    input int k, output logic gb, output logic gd,
    output logic [63:0] gbcd, output logic [63:0] gen,
    output logic gn, output logic go
  );
    if (k == 0) begin
      gb = busy_a; gd = done_a; gbcd = 64'(bcd_a);
      gen = 64'(en_a); gn = neg_a; go = ovf_a;
    end else begin
      gb = busy_b; gd = done_b; gbcd = 64'(bcd_b);
      gen = 64'(en_b); gn = neg_b; go = ovf_b;
    end
  endfunction

  task automatic drive(input int k, input logic s,
                       input logic [63:0] b, input logic sm);
    if (k == 0) begin
      start_a = s; bin_a = b[31:0]; sm_a = sm;
    end else begin
      start_b = s; bin_b = b[7:0]; sm_b = sm;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic        cb, cd, cn, co, xb, xd;
  logic [63:0] cbcd, cen;

  always @(negedge clk_100kHz) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        get(k, cb, cd, cbcd, cen, cn, co);
        xd = (cyc == done_cyc[k]);
        xb = (cyc >= busy_from[k]) && (cyc < idle_from[k]);
        checks++;
        if (cb !== xb || cd !== xd || cbcd !== exp_bcd[k] ||
            cen !== exp_en[k] || cn !== exp_neg[k] ||
            co !== exp_ovf[k]) begin
          errors++;
          $display("FAIL cycle%0d dut%0d: busy=%b done=%b bcd=%h en=%h neg=%b ovf=%b, want busy=%b done=%b bcd=%h en=%h neg=%b ovf=%b",
                   cyc, k, cb, cd, cbcd, cen, cn, co, xb, xd,
                   exp_bcd[k], exp_en[k], exp_neg[k], exp_ovf[k]);
        end
      end
    end
  end

  // ---------------- directed conversion ----------------
  task automatic wait_idle(input int k);
    logic tb_, td, tn, to;
    logic [63:0] tbc, te;
    int n;
    n = 0;
    get(k, tb_, td, tbc, te, tn, to);
    while (tb_ && n < 200) begin
      @(negedge clk_100kHz);
      n++;
      get(k, tb_, td, tbc, te, tn, to);
    end
  endtask

  task automatic run(input int k, input logic [63:0] b, input bit sm,
                     input string nm, input logic [63:0] ebcd,
                     input logic [63:0] een, input bit eneg,
                     input bit eovf);
    logic ab, ad, an, ao;
    logic [63:0] abcd, aen;
    int n;
    wait_idle(k);
    drive(k, 1'b1, b, sm);
    n = 0;
    ad = 0;
    do begin
      @(negedge clk_100kHz);
      n++;
      // scramble the inputs while busy; they must not matter
      if (n == 1) drive(k, 1'b0, {$urandom, $urandom}, 1'($urandom));
      get(k, ab, ad, abcd, aen, an, ao);
    end while (!ad && n < 200);
    checks++;
    if (!ad) begin
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles", nm, n);
    end else begin
      if (n != wid[k] + 2) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d",
                 nm, n, wid[k] + 2);
      end
      checks++;
      if (abcd !== ebcd || aen !== een || an !== eneg ||
          ao !== eovf) begin
        errors++;
        $display("FAIL %s: bcd=%h en=%h neg=%b ovf=%b, want bcd=%h en=%h neg=%b ovf=%b",
                 nm, abcd, aen, an, ao, ebcd, een, eneg, eovf);
      end
    end
  endtask

  logic [63:0] v, eb, ee;
  bit          s, en_, eo;
  int          dones;

  initial begin
    rst_ = 1; start_a = 0; sm_a = 0; bin_a = '0;
    start_b = 0; sm_b = 0; bin_b = '0;
    repeat (2) @(negedge clk_100kHz);
    rst_ = 0;

    run(0, 64'd12345678, 0, "dec12345678", 64'h12345678, 64'hFF, 0, 0);
    run(0, 64'd0, 0, "zero", 64'h0, 64'h01, 0, 0);
    run(0, 64'd505, 0, "dec505", 64'h505, 64'h07, 0, 0);
    run(0, 64'hFFFFFFFF, 1, "minus1", 64'h1, 64'h01, 1, 0);
    run(0, 64'hFFFFFF85, 1, "minus123", 64'h123, 64'h07, 1, 0);
    run(0, 64'd100000000, 0, "ovf_u", 64'h99999999, 64'hFF, 0, 1);
    run(0, 64'h80000000, 1, "ovf_s", 64'h99999999, 64'hFF, 1, 1);
    run(0, 64'd99999999, 0, "max_u", 64'h99999999, 64'hFF, 0, 0);
    run(0, 64'h80000000, 0, "big_u", 64'h99999999, 64'hFF, 0, 1);

    // second start while busy must be dropped
    wait_idle(0);
    drive(0, 1'b1, 64'd777, 1'b0);
    @(negedge clk_100kHz); drive(0, 1'b0, 64'd777, 1'b0);
    repeat (4) @(negedge clk_100kHz);
    drive(0, 1'b1, 64'd999, 1'b0);
    @(negedge clk_100kHz); drive(0, 1'b0, 64'd999, 1'b0);
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      if (done_a) dones++;
      @(negedge clk_100kHz);
    end
    checks++;
    if (dones != 1 || bcd_a !== 32'h777) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d bcd=%h want 1 and 777",
               dones, bcd_a);
    end

    // reset in the middle of a conversion
    wait_idle(0);
    drive(0, 1'b1, 64'd4321, 1'b0);
    @(negedge clk_100kHz); drive(0, 1'b0, 64'd4321, 1'b0);
    repeat (9) @(negedge clk_100kHz);
    rst_ = 1;
    @(negedge clk_100kHz);
    checks++;
    if (busy_a !== 0 || done_a !== 0 || bcd_a !== 32'h0 ||
        en_a !== 8'h01 || neg_a !== 0 || ovf_a !== 0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b bcd=%h en=%h neg=%b ovf=%b want reset values",
               busy_a, done_a, bcd_a, en_a, neg_a, ovf_a);
    end
    rst_ = 0;
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      if (done_a) dones++;
      @(negedge clk_100kHz);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL aborted_done: got %0d done pulses want 0", dones);
    end
    run(0, 64'd4321, 0, "after_reset", 64'h4321, 64'h0F, 0, 0);

    // small instance
    run(1, 64'd255, 0, "w8_255", 64'h255, 64'h7, 0, 0);
    run(1, 64'h80, 1, "w8_m128", 64'h128, 64'h7, 1, 0);
    run(1, 64'd7, 0, "w8_7", 64'h7, 64'h1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: v = 64'($urandom);
        1: v = 64'($urandom_range(0, 99999999));
        2: v = 64'($urandom_range(0, 999));
        default: v = 64'($urandom_range(99999990, 100000010));
      endcase
      s = 1'($urandom_range(0, 1));
      if (s && $urandom_range(0, 1) == 1) v = 64'(32'd0 - v[31:0]);
      ref_conv(32, 8, v, s, eb, ee, en_, eo);
      run(0, v, s, "rnd32", eb, ee, en_, eo);
    end
    for (int i = 0; i < 20; i++) begin
      v = 64'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      ref_conv(8, 3, v, s, eb, ee, en_, eo);
      run(1, v, s, "rnd8", eb, ee, en_, eo);
    end

    repeat (3) @(negedge clk_100kHz);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Parametrised, iterative (shift-add-3) binary-to-BCD converter with start/done handshake, optional two's-complement input, overflow saturation and leading-zero blanking. It replaces the fixed 32-bit/8-digit bin_to_bcd in front of the seven-segment display scanner. One conversion runs at a time. Results are held until the next conversion completes.

## Interface
- BIN_W, 32, binary input width; must be ≥ 4.
- DIGITS, 8, number of BCD output digits; must be ≥ 1.
- clk_100kHz  input  1  system clock; all logic on rising edge.
- rst_  input  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high).
- start  input  1  request conversion; sampled only in IDLE.
- signed_mode  input  1  1 = treat bin as two's complement; sampled with start.
- bin  input  BIN_W  value to convert; sampled with start.
- busy  output  1  high in LOAD, SHIFT and DONE.
- done  output  1  one-cycle pulse; outputs are valid and updated in this cycle.
- bcd  output  4*DIGITS  digit i at bits [4i+3:4i]; digit 0 is the least significant.
- en  output  DIGITS  per-digit display enable (leading-zero blanking).
- neg  output  1  result is negative (signed_mode only).
- ovf  output  1  magnitude ≥ 10^DIGITS; bcd is saturated.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE → LOAD when start=1.
  - Capture bin and signed_mode.
  - start=1 in any other state is ignored, with no queuing.
- LOAD (1 cycle):
  - Magnitude reg = (signed_mode && bin[BIN_W-1]) ? (~bin + 1) mod 2^BIN_W : bin.
  - neg_next = signed_mode && bin[BIN_W-1].
  - Clear the BCD scratch register, the sticky carry and the iteration counter.
  - The most negative input yields magnitude 2^(BIN_W-1), correct as an unsigned value.
- SHIFT (exactly BIN_W cycles), per cycle:
  - Every scratch digit ≥ 5 gets +3.
  - Shift {scratch, magnitude} left by 1.
  - The bit shifted out of the top digit ORs into sticky carry.
  - Counter width is $clog2(BIN_W+1). Leave SHIFT when the counter reaches BIN_W.
- DONE (1 cycle):
  - Register the outputs and assert done.
  - ovf = sticky carry.
  - bcd = ovf ? all digits 4'h9 : scratch.
  - neg = neg_next.
  - Then go to IDLE.
- en rule:
  - en[0]=1 always.
  - For i>0, en[i]=1 iff digit i or any higher digit is nonzero.
  - On ovf, en is all ones.
- Zero result: neg=0 even when signed_mode=1.
- Outputs change only in the DONE cycle or on reset.

## Timing
- Latency: start sampled at edge T → done high in cycle T+BIN_W+2. Default parameters give 34 cycles.
- Earliest next accepted start: the cycle after done, i.e. T+BIN_W+3. Throughput is one conversion per BIN_W+3 cycles.
- busy rises the cycle after start is sampled and falls together with done.
- Reset values: state IDLE, busy=0, done=0, bcd=0, en={{DIGITS-1{0}},1}, neg=0, ovf=0, scratch and counter 0.
- Reset mid-conversion: abort to IDLE, produce no done pulse, and load the reset values into the outputs.
- start and rst_ in the same cycle: rst_ wins and start is dropped.
- bin changing while busy has no effect.

## Structure
- Package bcd_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - localparam DIGIT_W=4;
  - function digit_adj3(input [3:0]) returning d≥5 ? d+3 : d.
- Sub-module bcd_dabble_stage (combinational, DIGITS generic) performs the per-digit adjust across the scratch register. It produces the adjusted vector and the shifted-out carry bit.
- Top holds the FSM, magnitude/scratch/counter registers, output registers and the en logic.

## Test plan
- Default parameters, bin=12345678, signed_mode=0, start for 1 cycle:
  - done exactly 34 cycles later;
  - bcd=32'h12345678, en=8'hFF, neg=0, ovf=0.
- bin=0 → bcd=0, en=8'h01, ovf=0. Then bin=505 → bcd=32'h00000505, en=8'h07.
- signed_mode=1, bin=32'hFFFFFFFF → neg=1, bcd=32'h00000001, en=8'h01. Then bin=32'hFFFFFF85 (−123) → neg=1, bcd=32'h00000123, en=8'h07.
- Overflow cases, each giving ovf=1, bcd=32'h99999999, en=8'hFF:
  - bin=100000000, unsigned;
  - signed_mode=1, bin=32'h80000000.
  - Then bin=99999999 unsigned → ovf=0, bcd=32'h99999999.
- Handshake cases:
  - start pulsed again 5 cycles after the first → ignored; exactly one done.
  - rst_ asserted 10 cycles into a conversion → no done; outputs equal reset values next cycle; a new start then converts correctly.
- Re-parametrise BIN_W=8, DIGITS=3:
  - bin=8'd255 → bcd=12'h255, done 10 cycles after start.
  - signed_mode=1, bin=8'h80 → neg=1, bcd=12'h128.
